// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory handshake, decode handshake and redirect controls.
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ack;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        jump_reg;
  logic        jump;
  logic        branch;
  logic        branch_taken;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] reg_target;
  logic        fault;

  modport master (
    output imem_req, imem_addr, instruction, instr_valid, pc, pc_plus4, fault,
    input  imem_ready, imem_rdata, instr_ack, jump_reg, jump, branch,
           branch_taken, imm16, imm26, reg_target
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_valid, pc, pc_plus4, fault,
    output imem_ready, imem_rdata, instr_ack, jump_reg, jump, branch,
           branch_taken, imm16, imm26, reg_target
  );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: holds the PC, fetches over req/ready and hands one
// instruction at a time to decode over valid/ack, applying redirects on ack.
//
//   state | meaning
//   FETCH | imem_req high, waiting for imem_ready (timeout counter running)
//   HOLD  | instruction presented to decode, waiting for instr_ack
//   FAULT | sticky error (misaligned jr or fetch timeout), only reset exits
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 255
) (
  input logic               clk,
  input logic               reset,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {FETCH, HOLD, FAULT} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [31:0] pc_q, pc_next;
  logic [31:0] instr_q, instr_next;
  logic        valid_q, valid_next;
  logic        fault_q, fault_next;
  logic [7:0]  cnt_q, cnt_next;

  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic [31:0] target;
  logic        jr_misaligned;

  assign pc_plus4      = pc_q + 32'd4;
  assign branch_off    = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  assign jr_misaligned = bus.jump_reg && (bus.reg_target[1:0] != 2'b00);

  always_comb begin
    target = pc_plus4;
    if (bus.jump_reg)
      target = bus.reg_target;
    else if (bus.jump)
      target = {pc_plus4[31:28], bus.imm26, 2'b00};
    else if (bus.branch && bus.branch_taken)
      target = pc_plus4 + branch_off;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= 8'h0;
    end else begin
      state   <= state_next;
      pc_q    <= pc_next;
      instr_q <= instr_next;
      valid_q <= valid_next;
      fault_q <= fault_next;
      cnt_q   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    instr_next = instr_q;
    valid_next = valid_q;
    fault_next = fault_q;
    cnt_next   = cnt_q;
    case (state)
      FETCH: begin
        if (bus.imem_ready) begin
          instr_next = bus.imem_rdata;
          valid_next = 1'b1;
          cnt_next   = 8'h0;
          state_next = HOLD;
        end else if (cnt_q == TIMEOUT_LAST) begin
          fault_next = 1'b1;
          state_next = FAULT;
        end else begin
          cnt_next = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (bus.instr_ack) begin
          valid_next = 1'b0;
          pc_next    = target;
          if (jr_misaligned) begin
            fault_next = 1'b1;
            state_next = FAULT;
          end else begin
            state_next = FETCH;
          end
        end
      end
      FAULT: begin
        valid_next = 1'b0;
        fault_next = 1'b1;
      end
      default: state_next = FETCH;
    endcase
  end

  // Request drops combinationally during reset so a reset mid-fetch aborts at once.
  assign bus.imem_req    = (state == FETCH) && !reset;
  assign bus.imem_addr   = pc_q;
  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.fault       = fault_q;

endmodule
